// File: rtl/ex_stage_unit.sv
// ex_stage_unit: execute stage (shifter, ALU, iterative multiplier) feeding the EX/MEM register.
// Optional EX_MUL_RADIX4_EN: multiplier retires two multiplier bits per step (WORD_W/2 steps).
module ex_stage_unit #(
  parameter int WORD_W    = 32,
  parameter int DST_W     = 4,
  parameter int MUL_STEPS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [WORD_W-1:0] pc_in,
  input  logic [WORD_W-1:0] val_rn,
  input  logic [WORD_W-1:0] val_rm,
  input  logic [11:0]       shifter_operand,
  input  logic [23:0]       signed_immediate,
  input  logic [3:0]        ex_command,
  input  logic              imm_in,
  input  logic [3:0]        status_in,
  input  logic              update_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              wb_en_in,
  input  logic              b_in,
  input  logic [DST_W-1:0]  dst_in,
  input  logic              flush,
  output logic              stall,
  output logic              valid_out,
  output logic [WORD_W-1:0] alu_result,
  output logic [WORD_W-1:0] store_data,
  output logic [WORD_W-1:0] branch_addr,
  output logic              branch_taken,
  output logic [3:0]        status_out,
  output logic              status_write,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              wb_en_out,
  output logic [DST_W-1:0]  dst_out
);

  // state | meaning
  // IDLE  | single-cycle ops issue; a MUL is accepted here
  // BUSY  | iterative multiply, cnt = step index
`ifdef EX_MUL_RADIX4_EN
  localparam int STEPS = WORD_W / 2;
  localparam int BPS   = 2;
`else
  localparam int STEPS = MUL_STEPS;
  localparam int BPS   = 1;
`endif
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);
  localparam int MSB = WORD_W - 1;

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  function automatic logic [WORD_W-1:0] ror_w(input logic [WORD_W-1:0] x, input logic [4:0] amt);
    return (x >> amt) | (x << (WORD_W - int'(amt)));
  endfunction

  logic              is_mul, accept, mul_done;
  logic [WORD_W-1:0] imm_ext, op2, alu_res, alu_d, baddr_d;
  logic [WORD_W:0]   sum;
  logic              c_flag, v_flag;
  logic [4:0]        shamt;

  assign is_mul   = (ex_command == OP_MUL);
  assign accept   = (state == IDLE) && valid_in && is_mul;
  assign mul_done = (state == BUSY) && (cnt == LAST);
  assign imm_ext  = {{(WORD_W-8){1'b0}}, shifter_operand[7:0]};
  assign shamt    = shifter_operand[11:7];
  assign baddr_d  = pc_in + ({{(WORD_W-24){signed_immediate[23]}}, signed_immediate} << 2);

  always_comb begin
    op2 = val_rm;
    if (imm_in) begin
      op2 = ror_w(imm_ext, {shifter_operand[11:8], 1'b0});
    end else begin
      case (shifter_operand[6:5])
        2'b00:   op2 = val_rm << shamt;
        2'b01:   op2 = val_rm >> shamt;
        2'b10:   op2 = $unsigned($signed(val_rm) >>> shamt);
        default: op2 = ror_w(val_rm, shamt);
      endcase
    end
  end

  // Subtraction is rn + ~op2 + carry so the carry out is directly NOT borrow.
  always_comb begin
    sum     = '0;
    alu_res = op2;
    c_flag  = status_in[1];
    v_flag  = status_in[0];
    case (ex_command)
      OP_MOV: alu_res = op2;
      OP_MVN: alu_res = ~op2;
      OP_ADD, OP_ADC: begin
        sum = {1'b0, val_rn} + {1'b0, op2}
            + {{WORD_W{1'b0}}, (ex_command == OP_ADC) ? status_in[1] : 1'b0};
        alu_res = sum[MSB:0];
        c_flag  = sum[WORD_W];
        v_flag  = (val_rn[MSB] == op2[MSB]) && (alu_res[MSB] != val_rn[MSB]);
      end
      OP_SUB, OP_SBC: begin
        sum = {1'b0, val_rn} + {1'b0, ~op2}
            + {{WORD_W{1'b0}}, (ex_command == OP_SBC) ? status_in[1] : 1'b1};
        alu_res = sum[MSB:0];
        c_flag  = sum[WORD_W];
        v_flag  = (val_rn[MSB] != op2[MSB]) && (alu_res[MSB] != val_rn[MSB]);
      end
      OP_AND: alu_res = val_rn & op2;
      OP_ORR: alu_res = val_rn | op2;
      OP_EOR: alu_res = val_rn ^ op2;
      default: alu_res = op2;
    endcase
  end

  assign alu_d = (mem_read_in || mem_write_in) ? (val_rn + op2) : alu_res;

  logic [WORD_W-1:0] m_acc, m_cand, m_plier, partial, acc_nxt;
  logic [WORD_W-1:0] l_rm, l_baddr;
  logic [DST_W-1:0]  l_dst;
  logic              l_update, l_mr, l_mw, l_wb, l_b;

`ifdef EX_MUL_RADIX4_EN
  always_comb begin
    case (m_plier[1:0])
      2'd0:    partial = '0;
      2'd1:    partial = m_cand;
      2'd2:    partial = m_cand << 1;
      default: partial = m_cand + (m_cand << 1);
    endcase
  end
`else
  assign partial = m_plier[0] ? m_cand : '0;
`endif
  assign acc_nxt = m_acc + partial;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    if (state == IDLE) begin
      if (valid_in && is_mul) begin
        state_nxt = BUSY;
        cnt_nxt   = '0;
        stall     = 1'b1;
      end
    end else begin
      if (cnt == LAST) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
        stall   = 1'b1;
      end
    end
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      stall     = 1'b0;
    end
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out     <= 1'b0;
      alu_result    <= '0;
      store_data    <= '0;
      branch_addr   <= '0;
      branch_taken  <= 1'b0;
      status_out    <= '0;
      status_write  <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
      wb_en_out     <= 1'b0;
      dst_out       <= '0;
      m_acc         <= '0;
      m_cand        <= '0;
      m_plier       <= '0;
      l_rm          <= '0;
      l_baddr       <= '0;
      l_dst         <= '0;
      l_update      <= 1'b0;
      l_mr          <= 1'b0;
      l_mw          <= 1'b0;
      l_wb          <= 1'b0;
      l_b           <= 1'b0;
    end else if (flush) begin
      valid_out     <= 1'b0;
      status_write  <= 1'b0;
      branch_taken  <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
      wb_en_out     <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        m_acc         <= '0;
        m_cand        <= val_rn;
        m_plier       <= val_rm;
        l_rm          <= val_rm;
        l_baddr       <= baddr_d;
        l_dst         <= dst_in;
        l_update      <= update_in;
        l_mr          <= mem_read_in;
        l_mw          <= mem_write_in;
        l_wb          <= wb_en_in;
        l_b           <= b_in;
        valid_out     <= 1'b0;
        status_write  <= 1'b0;
        branch_taken  <= 1'b0;
        mem_read_out  <= 1'b0;
        mem_write_out <= 1'b0;
        wb_en_out     <= 1'b0;
      end else begin
        valid_out     <= valid_in;
        alu_result    <= alu_d;
        store_data    <= val_rm;
        branch_addr   <= baddr_d;
        status_out    <= {alu_res[MSB], (alu_res == '0), c_flag, v_flag};
        status_write  <= valid_in && update_in && !mem_read_in && !mem_write_in && !b_in;
        branch_taken  <= valid_in && b_in;
        mem_read_out  <= valid_in && mem_read_in;
        mem_write_out <= valid_in && mem_write_in;
        wb_en_out     <= valid_in && wb_en_in;
        dst_out       <= dst_in;
      end
    end else begin
      m_acc   <= acc_nxt;
      m_cand  <= m_cand << BPS;
      m_plier <= m_plier >> BPS;
      if (mul_done) begin
        valid_out     <= 1'b1;
        alu_result    <= acc_nxt;
        store_data    <= l_rm;
        branch_addr   <= l_baddr;
        status_out    <= {l_update ? acc_nxt[MSB] : status_in[3],
                          l_update ? (acc_nxt == '0) : status_in[2],
                          status_in[1:0]};
        status_write  <= l_update && !l_mr && !l_mw && !l_b;
        branch_taken  <= l_b;
        mem_read_out  <= l_mr;
        mem_write_out <= l_mw;
        wb_en_out     <= l_wb;
        dst_out       <= l_dst;
      end
    end
  end

endmodule
